// File: rtl/dc_requant.sv
// Requantizes the Q9.23 DC-filter output to 9-bit signed samples using
// first-order error feedback, round-half-up, saturation and a post-reset mute window.
module dc_requant #(
  parameter int N_DECIMALS   = 23,
  parameter int MUTE_SAMPLES = 64,
  parameter int CNT_W        = 16
) (
  input  logic                    CLK_24M,
  input  logic                    reset,
  input  logic                    enable_3M,
  input  logic [N_DECIMALS+8:0]   filter_in,
  input  logic                    mute_req,
  input  logic                    clip_count_clr,
  output logic signed [8:0]       data_out,
  output logic                    out_valid,
  output logic                    clip,
  output logic [CNT_W-1:0]        clip_count,
  output logic                    running
);

  localparam int IN_W   = N_DECIMALS + 9;
  localparam int ACC_W  = IN_W + 2;
  localparam int ERR_W  = N_DECIMALS + 1;
  localparam int MCNT_W = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;

  localparam logic signed [ACC_W-1:0] HALF_LSB = {{(ACC_W-N_DECIMALS){1'b0}}, 1'b1, {(N_DECIMALS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Q_MAX    = {{(ACC_W-9){1'b0}}, 9'h0FF};
  localparam logic signed [ACC_W-1:0] Q_MIN    = {{(ACC_W-9){1'b1}}, 9'h100};
  localparam logic [MCNT_W-1:0]       MCNT_LAST = MCNT_W'(MUTE_SAMPLES - 1);

  typedef enum logic [0:0] {
    ST_MUTE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [IN_W-1:0]          in_r;
  logic                     pend_r;
  logic signed [ERR_W-1:0]  err_r;
  state_t                   state_r;
  logic [MCNT_W-1:0]        mcnt_r;

  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  round_s;
  logic signed [ACC_W-1:0]  q_s;
  logic signed [ACC_W-1:0]  resid_s;

  state_t                   state_next_s;
  logic [MCNT_W-1:0]        mcnt_next_s;
  logic signed [8:0]        dout_next_s;
  logic                     clip_next_s;
  logic signed [ERR_W-1:0]  err_next_s;
  logic                     run_out_s;

  // Sample capture: the pending flag marks the following cycle as the compute cycle.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      in_r   <= {IN_W{1'b0}};
      pend_r <= 1'b0;
    end else begin
      pend_r <= enable_3M;
      if (enable_3M) begin
        in_r <= filter_in;
      end else begin
        in_r <= in_r;
      end
    end
  end

  // Error-feedback rounding datapath, wide enough that the sum cannot overflow.
  always_comb begin
    sum_s   = {{(ACC_W-IN_W){in_r[IN_W-1]}}, in_r} + {{(ACC_W-ERR_W){err_r[ERR_W-1]}}, err_r};
    round_s = sum_s + HALF_LSB;
    q_s     = round_s >>> N_DECIMALS;
    resid_s = sum_s - (q_s <<< N_DECIMALS);
  end

  // Mute/run sequencing and saturation decisions, evaluated only on compute cycles.
  always_comb begin
    state_next_s = state_r;
    mcnt_next_s  = mcnt_r;
    dout_next_s  = 9'sd0;
    clip_next_s  = 1'b0;
    err_next_s   = err_r;
    run_out_s    = 1'b0;
    if (pend_r) begin
      case (state_r)
        ST_MUTE: begin
          err_next_s = {ERR_W{1'b0}};
          if (mute_req) begin
            mcnt_next_s = {MCNT_W{1'b0}};
          end else if (mcnt_r == MCNT_LAST) begin
            state_next_s = ST_RUN;
            mcnt_next_s  = {MCNT_W{1'b0}};
          end else begin
            mcnt_next_s = mcnt_r + MCNT_W'(1);
          end
        end
        ST_RUN: begin
          if (mute_req) begin
            state_next_s = ST_MUTE;
            mcnt_next_s  = {MCNT_W{1'b0}};
            err_next_s   = {ERR_W{1'b0}};
          end else begin
            run_out_s = 1'b1;
            if (q_s > Q_MAX) begin
              // Zeroing the error on saturation keeps the feedback from winding up.
              dout_next_s = 9'sh0FF;
              clip_next_s = 1'b1;
              err_next_s  = {ERR_W{1'b0}};
            end else if (q_s < Q_MIN) begin
              dout_next_s = -9'sd256;
              clip_next_s = 1'b1;
              err_next_s  = {ERR_W{1'b0}};
            end else begin
              dout_next_s = q_s[8:0];
              clip_next_s = 1'b0;
              err_next_s  = resid_s[ERR_W-1:0];
            end
          end
        end
        default: begin
          state_next_s = ST_MUTE;
          mcnt_next_s  = {MCNT_W{1'b0}};
          err_next_s   = {ERR_W{1'b0}};
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Output, error and state registers; data holds between output pulses.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      data_out  <= 9'sd0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      running   <= 1'b0;
      err_r     <= {ERR_W{1'b0}};
      state_r   <= ST_MUTE;
      mcnt_r    <= {MCNT_W{1'b0}};
    end else begin
      out_valid <= pend_r;
      if (pend_r) begin
        data_out <= dout_next_s;
        clip     <= clip_next_s;
        running  <= run_out_s;
        err_r    <= err_next_s;
        state_r  <= state_next_s;
        mcnt_r   <= mcnt_next_s;
      end else begin
        data_out <= data_out;
        clip     <= clip;
        running  <= running;
        err_r    <= err_r;
        state_r  <= state_r;
        mcnt_r   <= mcnt_r;
      end
    end
  end

  // Saturating clip event counter; a clear overrides a simultaneous increment.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      clip_count <= {CNT_W{1'b0}};
    end else if (clip_count_clr) begin
      clip_count <= {CNT_W{1'b0}};
    end else if (pend_r && clip_next_s && (clip_count != {CNT_W{1'b1}})) begin
      clip_count <= clip_count + CNT_W'(1);
    end else begin
      clip_count <= clip_count;
    end
  end

endmodule

// File: tb/tb_dc_requant.sv
// Randomized scoreboard bench for dc_requant with a real-arithmetic reference model.
module tb_dc_requant;

  localparam int CNT_W  = 8;
  localparam int MUTE_N = 64;
  localparam int CC_MAX = (1 << CNT_W) - 1;

  logic              CLK_24M;
  logic              reset;
  logic              enable_3M;
  logic [31:0]       filter_in;
  logic              mute_req;
  logic              clip_count_clr;
  logic signed [8:0] data_out;
  logic              out_valid;
  logic              clip;
  logic [CNT_W-1:0]  clip_count;
  logic              running;

  dc_requant #(.N_DECIMALS(23), .MUTE_SAMPLES(MUTE_N), .CNT_W(CNT_W)) dut (
    .CLK_24M(CLK_24M), .reset(reset), .enable_3M(enable_3M), .filter_in(filter_in),
    .mute_req(mute_req), .clip_count_clr(clip_count_clr), .data_out(data_out),
    .out_valid(out_valid), .clip(clip), .clip_count(clip_count), .running(running)
  );

  initial CLK_24M = 1'b0;
  always #21 CLK_24M = ~CLK_24M;

  typedef struct {
    longint d;
    longint c;
    longint r;
    longint cc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint m_err;
  int     m_left;
  int     m_cc;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_err  = 0;
    m_left = MUTE_N;
    m_cc   = 0;
    exp_q.delete();
  endtask

  // Reference: output = round-half-up((x + carried error) / 2^23), saturated to 9 bits.
  task automatic model_push(input logic [31:0] x, input logic m, input logic clr);
    exp_t   e;
    longint s;
    longint q;
    s = longint'($signed(x)) + m_err;
    e.d = 0; e.c = 0; e.r = 0;
    if (m) begin
      m_left = MUTE_N;
      m_err  = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_err = 0;
    end else begin
      e.r = 1;
      q = longint'($rtoi($floor(real'(s) / 8388608.0 + 0.5)));
      if (q > 255) begin
        e.d = 255; e.c = 1; m_err = 0;
      end else if (q < -256) begin
        e.d = -256; e.c = 1; m_err = 0;
      end else begin
        e.d = q; m_err = s - q * 8388608;
      end
    end
    if (clr) m_cc = 0;
    else if (e.c == 1 && m_cc < CC_MAX) m_cc++;
    e.cc = m_cc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] x, input logic m, input logic clr, input int gap);
    @(posedge CLK_24M); #1;
    mute_req  = m;
    filter_in = x;
    enable_3M = 1'b1;
    model_push(x, m, clr);
    @(posedge CLK_24M); #1;
    enable_3M      = 1'b0;
    clip_count_clr = clr;
    @(posedge CLK_24M); #1;
    @(posedge CLK_24M); #1;
    clip_count_clr = 1'b0;
    repeat (gap - 3) @(posedge CLK_24M);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge CLK_24M);
    chk({tag, "_data_out"}, longint'(data_out), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_clip"}, longint'(clip), 0);
    chk({tag, "_clip_count"}, longint'(clip_count), 0);
    chk({tag, "_running"}, longint'(running), 0);
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
      2: v = 32'h7F80_0000 + 32'($urandom_range(0, 32'h0080_0000)) - 32'h0040_0000;
      default: v = 32'h8000_0000 + 32'($urandom_range(0, 32'h0080_0000));
    endcase
    return v;
  endfunction

  // Monitor: enforces the 2-clock latency and scores every output pulse.
  logic [2:0] hist;
  always @(negedge CLK_24M) begin
    exp_t e;
    if (reset) begin
      hist = 3'b000;
    end else begin
      hist = {hist[1:0], enable_3M};
      if (out_valid || hist[2]) chk("out_valid_latency", longint'(out_valid), longint'(hist[2]));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got out_valid=1 data_out=%0d, expected no output", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", longint'(data_out), e.d);
          chk("clip", longint'(clip), e.c);
          chk("running", longint'(running), e.r);
          chk("clip_count", longint'(clip_count), e.cc);
        end
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; enable_3M = 1'b0; filter_in = 32'h0; mute_req = 1'b0; clip_count_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK_24M);
    check_zero_outputs("reset");
    @(posedge CLK_24M); #1;
    reset = 1'b0;

    // Mute window, then 1.5 alternating 2/1
    for (int i = 0; i < MUTE_N + 8; i++) issue(32'h00C0_0000, 1'b0, 1'b0, 8);

    // Positive clip resets error; next 0.5 rounds to 1
    issue(32'h7FFF_FFFF, 1'b0, 1'b0, 8);
    issue(32'h0040_0000, 1'b0, 1'b0, 8);
    issue(32'h0040_0000, 1'b0, 1'b0, 8);

    // Most negative input is exactly -256; then -1.5 alternates -1/-2
    issue(32'h8000_0000, 1'b0, 1'b0, 8);
    for (int i = 0; i < 4; i++) issue(32'hFF40_0000, 1'b0, 1'b0, 9);

    for (int i = 0; i < 150; i++)
      issue(rand_sample(), ($urandom_range(0, 19) == 0), 1'b0, $urandom_range(8, 12));

    // Mute request in RUN for three samples, then settle and resume
    for (int i = 0; i < 3; i++) issue(32'h00C0_0000, 1'b1, 1'b0, 8);
    for (int i = 0; i < MUTE_N + 6; i++) issue(32'h00C0_0000, 1'b0, 1'b0, 8);

    // Reset between an enable and its output pulse
    @(posedge CLK_24M); #1;
    filter_in = 32'h00C0_0000; enable_3M = 1'b1;
    @(posedge CLK_24M); #1;
    enable_3M = 1'b0; reset = 1'b1;
    model_reset();
    check_zero_outputs("midreset");
    repeat (2) @(posedge CLK_24M); #1;
    reset = 1'b0;
    repeat (4) @(posedge CLK_24M);

    // Saturate clip_count, then clear it against a simultaneous clip
    for (int i = 0; i < MUTE_N; i++) issue(rand_sample(), 1'b0, 1'b0, 8);
    for (int i = 0; i < CC_MAX + 20; i++) issue(32'h7FFF_FFFF, 1'b0, 1'b0, 8);
    issue(32'h7FFF_FFFF, 1'b0, 1'b1, 8);
    issue(32'h8100_0000, 1'b0, 1'b0, 8);
    issue(32'h0000_0000, 1'b0, 1'b0, 8);
    issue(32'h7FFF_FFFF, 1'b0, 1'b0, 8);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge CLK_24M);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outputs outstanding, expected 0", exp_q.size());
    end
    repeat (4) @(posedge CLK_24M);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dc_requant.md
Name: dc_requant

Overview:
- Output end of the DC-blocking filter path: consumes the filter's signed Q9.23 sample stream (32 bits, 23 fractional) at the 3 MHz sample enable and returns it to 9-bit signed integer samples.
- Uses first-order error-feedback noise shaping, round-half-up, saturation and a post-reset mute/settle state machine.
- Sits between the DC filter output and the downstream 9-bit data consumers, in the CLK_24M domain.

Parameters:
- N_DECIMALS, 23, fractional bits of filter_in.
- MUTE_SAMPLES, 64, samples forced to zero after reset or mute release while the filter settles.
- CNT_W, 16, width of the clip event counter.

Ports:
- CLK_24M  input  1  system clock, 24 MHz.
- reset  input  1  asynchronous, active-high reset.
- enable_3M  input  1  one-cycle sample strobe, at most one per 8 clocks.
- filter_in  input  N_DECIMALS+9  signed Q9.23 filtered sample, valid in enable_3M cycles.
- mute_req  input  1  level; forces the MUTE state while high.
- clip_count_clr  input  1  synchronous clear of clip_count.
- data_out  output  9  signed requantized sample.
- out_valid  output  1  one-cycle pulse when data_out updates.
- clip  output  1  high with out_valid when the current sample saturated.
- clip_count  output  CNT_W  saturating count of clipped samples.
- running  output  1  high in the RUN state.

Behaviour:
- Reset (asynchronous, active-high):
  - data_out = 0, out_valid = 0, clip = 0, clip_count = 0, running = 0.
  - Error register err = 0; state = MUTE; mute counter = 0; input register = 0.
- Pipeline timing:
  - Edge at end of enable cycle T: filter_in is captured into in_r and a pending flag is set.
  - Edge at end of cycle T+1: the quantizer computes and registers data_out, clip and err.
  - out_valid is high during cycle T+2 for exactly one clock. Latency is 2 clocks.
- Quantizer arithmetic, at least 34-bit signed internally:
  - s = sext(in_r) + sext(err).
  - q = (s + 2^(N_DECIMALS-1)) >>> N_DECIMALS. Ties round toward +inf.
  - If q > 255: data_out = 255, clip = 1, err_next = 0. The zeroed error prevents windup.
  - If q < -256: data_out = -256, clip = 1, err_next = 0.
  - Otherwise: data_out = q, clip = 0, err_next = s - (q << N_DECIMALS). err stays in [-2^22, 2^22) and is stored as 24-bit signed.
- State machine, advancing only on quantizer (compute) cycles:
  - MUTE:
    - data_out = 0, clip = 0, err held at 0, out_valid still pulses.
    - The mute counter increments per sample.
    - After MUTE_SAMPLES muted outputs with mute_req low: go to RUN. The next sample is the first real one.
    - mute_req high holds the counter at 0.
  - RUN:
    - Normal quantization; running = 1.
    - mute_req high at a compute cycle: that sample and all following are muted, the state goes to MUTE with counter 0, and err is cleared.
- clip_count:
  - Increments on each clip = 1 output and saturates at all-ones.
  - clip_count_clr wins over a simultaneous increment.
- Boundary cases:
  - enable_3M in a compute cycle cannot occur (spacing ≥ 8); no behaviour is defined for it.
  - Reset mid-pipeline drops the pending sample; no out_valid follows.
  - filter_in = 0x80000000 gives q = -256 exactly, so no clip.

Test Plan:
- Reset, then 64 samples of 0x00C00000: data_out = 0 for 64 pulses, running = 0. Afterward data_out alternates 2, 1, 2, 1 and running = 1.
- In RUN, filter_in = 0x7FFFFFFF: data_out = 255, clip = 1, clip_count increments; the next sample of 0x00400000 gives data_out = 1, since err was zeroed.
- In RUN, filter_in = 0x80000000: data_out = -256, clip = 0. Then 0xFF400000 (-1.5) gives -1 (round half up), then -2, alternating.
- Check latency: out_valid rises exactly 2 clocks after each enable_3M, lasts 1 clock, and never appears without a preceding enable.
- Assert mute_req for 3 samples in RUN: data_out = 0 for those samples plus 64 more after release, then returns to RUN. Assert reset between an enable and its out_valid: no pulse follows and all outputs return to 0.
- Drive clip_count to 0xFFFF with full-scale input: it stays at 0xFFFF. Assert clip_count_clr with a simultaneous clip: clip_count = 0.
